// File: rtl/mpu_pkg.sv
// mpu_pkg: shared MPU constants and enums.
//   FP / M / N            element width and maximum matrix dimensions
//   MBITS / NBITS         row / column index widths (size ports are one bit wider)
//   MATRIX_REG_SIZE       register-file address width
//   mpu_operation_t       top-level MPU operation codes
//   store_state_t         mpu_store controller states
package mpu_pkg;
  localparam int FP              = 32;
  localparam int M               = 4;
  localparam int N               = 4;
  localparam int MBITS           = $clog2(M);
  localparam int NBITS           = $clog2(N);
  localparam int MATRIX_REG_SIZE = 2;

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_STORE,
    OP_ADD,
    OP_MUL
  } mpu_operation_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    STREAM,
    DONE,
    ERR
  } store_state_t;
endpackage

// File: rtl/mpu_index_counter.sv
// mpu_index_counter: row-major (i,j) walker over an m x n matrix.
//   clk, rst   clock, synchronous active-high reset
//   clr_i      restart at (0,0)
//   adv_i      step to the next element (one transfer accepted)
//   m_i, n_i   matrix bounds (1..M, 1..N)
//   i_o, j_o   current row / column
//   last_o     current position is (m-1, n-1)
module mpu_index_counter
  import mpu_pkg::*;
#(
  parameter int MW = MBITS + 1,
  parameter int NW = NBITS + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic [MW-1:0] m_i,
  input  logic [NW-1:0] n_i,
  output logic [MW-1:0] i_o,
  output logic [NW-1:0] j_o,
  output logic          last_o
);
  logic [MW-1:0] i_q, i_d;
  logic [NW-1:0] j_q, j_d;
  logic          col_end;

  assign col_end = (j_q == n_i - NW'(1));
  assign last_o  = col_end && (i_q == m_i - MW'(1));

  // The counter parks on the last element instead of stepping past it, so
  // indices never exceed the matrix bounds.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
    end else if (adv_i && !last_o) begin
      if (col_end) begin
        j_d = '0;
        i_d = i_q + MW'(1);
      end else begin
        j_d = j_q + NW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i_o = i_q;
  assign j_o = j_q;
endmodule

// File: rtl/mpu_store.sv
// mpu_store: reads one matrix from the register file and streams it row-major.
//   clk, rst                 clock, synchronous active-high reset
//   en, store_addr           start request (IDLE only) and entry to read
//   reg_store_addr           read address to the register file
//   matrix_in, reg_m_size,
//   reg_n_size               registered read data from the register file
//   element_out/valid/ready  element stream (valid/ready handshake)
//   m_out, n_out             dimensions of the matrix being streamed
//   busy, ack, error         status; ack/error are one-cycle pulses
module mpu_store
  import mpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [MATRIX_REG_SIZE-1:0] store_addr,
  output logic [MATRIX_REG_SIZE-1:0] reg_store_addr,
  input  logic [M*N*FP-1:0]          matrix_in,
  input  logic [MBITS:0]             reg_m_size,
  input  logic [NBITS:0]             reg_n_size,
  output logic [FP-1:0]              element_out,
  output logic                       element_valid,
  input  logic                       element_ready,
  output logic [MBITS:0]             m_out,
  output logic [NBITS:0]             n_out,
  output logic                       busy,
  output logic                       ack,
  output logic                       error
);
  localparam int IW = $clog2(M*N);

  store_state_t                state_q, state_d;
  logic [M*N-1:0][FP-1:0]      buf_q;
  logic [MATRIX_REG_SIZE-1:0]  addr_q;
  logic [MBITS:0]              m_q;
  logic [NBITS:0]              n_q;
  logic [MBITS:0]              row;
  logic [NBITS:0]              col;
  logic [IW-1:0]               idx;
  logic                        last, xfer, dims_bad;

  assign dims_bad = (reg_m_size == '0) || (reg_n_size == '0) ||
                    (reg_m_size > (MBITS+1)'(M)) || (reg_n_size > (NBITS+1)'(N));
  assign xfer     = element_valid && element_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = FETCH;
      FETCH:   state_d = CAPTURE;
      CAPTURE: state_d = dims_bad ? ERR : STREAM;
      STREAM:  if (xfer && last) state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Local snapshot: later register-file writes cannot disturb the stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      buf_q  <= '0;
      m_q    <= '0;
      n_q    <= '0;
    end else begin
      if (state_q == IDLE && en) addr_q <= store_addr;
      if (state_q == CAPTURE) begin
        buf_q <= matrix_in;
        m_q   <= reg_m_size;
        n_q   <= reg_n_size;
      end
    end
  end

  mpu_index_counter #(.MW(MBITS + 1), .NW(NBITS + 1)) u_idx (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == CAPTURE),
    .adv_i  (xfer),
    .m_i    (m_q),
    .n_i    (n_q),
    .i_o    (row),
    .j_o    (col),
    .last_o (last)
  );

  // Indices stay inside the captured bounds, so the flat index never overflows.
  assign idx            = IW'(int'(row) * N + int'(col));
  assign element_out    = buf_q[idx];
  assign element_valid  = (state_q == STREAM);
  assign ack            = (state_q == DONE);
  assign error          = (state_q == ERR);
  assign busy           = (state_q != IDLE);
  assign reg_store_addr = addr_q;
  assign m_out          = m_q;
  assign n_out          = n_q;
endmodule

// File: tb/tb_mpu_store.sv
// tb_mpu_store: directed + randomized bench for mpu_store with a small
// register-file model and a queue-based expected-element model.
module tb_mpu_store;
  import mpu_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst, en, element_ready;
  logic [MATRIX_REG_SIZE-1:0] store_addr, reg_store_addr;
  logic [M*N*FP-1:0]          matrix_in;
  logic [MBITS:0]             reg_m_size, m_out;
  logic [NBITS:0]             reg_n_size, n_out;
  logic [FP-1:0]              element_out;
  logic                       element_valid, busy, ack, error;

  int vectors = 0;
  int miscompares = 0;

  logic [M*N-1:0][FP-1:0] rf_mat [4];
  logic [MBITS:0]         rf_m   [4];
  logic [NBITS:0]         rf_n   [4];
  logic [31:0]            fv     [16];
  int                     pat    [7];

  always #5 clk = ~clk;

  // Register file with a registered read port.
  always @(posedge clk) begin
    matrix_in  <= rf_mat[reg_store_addr];
    reg_m_size <= rf_m[reg_store_addr];
    reg_n_size <= rf_n[reg_store_addr];
  end

  mpu_store dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .store_addr     (store_addr),
    .reg_store_addr (reg_store_addr),
    .matrix_in      (matrix_in),
    .reg_m_size     (reg_m_size),
    .reg_n_size     (reg_n_size),
    .element_out    (element_out),
    .element_valid  (element_valid),
    .element_ready  (element_ready),
    .m_out          (m_out),
    .n_out          (n_out),
    .busy           (busy),
    .ack            (ack),
    .error          (error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_mat(input int a, input int m, input int n);
    rf_m[a] = 3'(m);
    rf_n[a] = 3'(n);
    rf_mat[a] = '0;
  endtask

  // rmode: 0 ready always high, 1 fixed toggle pattern, 2 random.
  task automatic run_store(input int addr, input int rmode, input bit inj_en, input bit mutate);
    logic [31:0] q[$];
    logic [31:0] prev_elem;
    int m, n, k, first_k, last_k, pidx;
    bit err, prev_stall, done, rdy;
    m = int'(rf_m[addr]);
    n = int'(rf_n[addr]);
    err = (m == 0) || (n == 0) || (m > M) || (n > N);
    q = {};
    if (!err)
      for (int i = 0; i < m; i++)
        for (int j = 0; j < n; j++) q.push_back(rf_mat[addr][i*N+j]);
    @(negedge clk);
    en = 1'b1; store_addr = 2'(addr); element_ready = 1'b0;
    @(negedge clk);
    en = 1'b0; k = 1;
    chk("addr_latch", reg_store_addr, addr);
    first_k = 0; last_k = 0; prev_stall = 0; done = 0; pidx = 0; prev_elem = '0;
    while (!done) begin
      element_ready = 1'b0;
      if (k < 3) begin
        chk("pre_stream", {busy, element_valid, ack, error}, 4'b1000);
      end else if (err) begin
        chk("err_pulse", {busy, element_valid, ack, error}, 4'b1001);
        @(negedge clk);
        chk("err_end", {busy, element_valid, ack, error}, 4'b0000);
        done = 1;
      end else if (ack) begin
        chk("ack_after_last", k, last_k + 1);
        chk("ack_left", q.size(), 0);
        chk("ack_valid", element_valid, 1'b0);
        chk("addr_hold", reg_store_addr, addr);
        if (rmode == 0) chk("ack_latency", k, 3 + m*n);
        @(negedge clk);
        chk("ack_pulse", {busy, ack, element_valid}, 3'b000);
        done = 1;
      end else if (element_valid) begin
        if (first_k == 0) begin
          first_k = k;
          chk("first_valid", k, 3);
          chk("m_out", m_out, m);
          chk("n_out", n_out, n);
        end
        if (prev_stall) chk("hold", element_out, prev_elem);
        if (q.size() == 0) chk("extra_elem", 1, 0);
        else               chk("elem", element_out, q[0]);
        case (rmode)
          0:       rdy = 1'b1;
          1:       begin rdy = pat[pidx % 7] != 0; pidx++; end
          default: rdy = ($urandom_range(0, 1) == 1);
        endcase
        element_ready = rdy;
        if (rdy) begin
          if (q.size() != 0) void'(q.pop_front());
          last_k = k;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
        end
        prev_elem = element_out;
      end else begin
        chk("valid_gap", element_valid, 1'b1);
        done = 1;
      end
      en = (inj_en && k == 4);
      if (inj_en && k == 4) store_addr = ~2'(addr);
      if (mutate && k == 3) for (int e = 0; e < M*N; e++) rf_mat[addr][e] = $urandom;
      if (!done) begin
        @(negedge clk);
        k++;
        if (k > 400) begin chk("timeout", 1, 0); done = 1; end
      end
    end
    en = 1'b0; element_ready = 1'b0;
  endtask

  initial begin
    fv = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000,
           32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
           32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    pat = '{1, 0, 0, 1, 0, 1, 1};
    for (int a = 0; a < 4; a++) set_mat(a, 0, 0);
    rst = 1'b1; en = 1'b0; store_addr = '0; element_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_flags", {busy, element_valid, ack, error}, 4'b0000);
    chk("reset_data", {element_out, m_out, n_out, reg_store_addr}, '0);

    // 2x2 {1.0, 50.33, -2.5, 0.125}
    set_mat(0, 2, 2);
    rf_mat[0][0] = 32'h3f800000; rf_mat[0][1] = 32'h424951ec;
    rf_mat[0][N] = 32'hc0200000; rf_mat[0][N+1] = 32'h3e000000;
    run_store(0, 0, 0, 0);
    run_store(0, 1, 0, 0);

    // 4x4 of 1.0..16.0, then 3x1
    set_mat(1, 4, 4);
    for (int e = 0; e < 16; e++) rf_mat[1][e] = fv[e];
    run_store(1, 0, 0, 0);
    set_mat(0, 3, 1);
    for (int i = 0; i < 3; i++) rf_mat[0][i*N] = fv[i+4];
    run_store(0, 0, 0, 0);

    // illegal dimensions
    set_mat(2, 0, 2); run_store(2, 0, 0, 0);
    set_mat(3, 5, 2); run_store(3, 0, 0, 0);
    set_mat(2, 2, 0); run_store(2, 0, 0, 0);
    set_mat(3, 3, 5); run_store(3, 0, 0, 0);

    // en during stream is ignored
    set_mat(0, 2, 2);
    rf_mat[0][0] = 32'h3f800000; rf_mat[0][1] = 32'h424951ec;
    rf_mat[0][N] = 32'hc0200000; rf_mat[0][N+1] = 32'h3e000000;
    run_store(0, 0, 1, 0);

    // reset mid-stream, then clean restart
    @(negedge clk);
    en = 1'b1; store_addr = 2'd0;
    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_streaming", element_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_flags", {busy, element_valid, ack, error}, 4'b0000);
    run_store(0, 0, 0, 0);

    // randomized matrices, ready and post-capture register-file writes
    for (int t = 0; t < 24; t++) begin
      int a, m, n;
      a = $urandom_range(0, 3);
      m = $urandom_range(1, 4);
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 1) m = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(5, 7);
        else                           n = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(5, 7);
      end
      set_mat(a, m, n);
      for (int e = 0; e < M*N; e++) rf_mat[a][e] = $urandom;
      run_store(a, 2, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mpu_store.md
Name: mpu_store

Overview:
- Downstream counterpart of mpu_load. Reads one matrix out of mpu_register_file and streams its elements row-major to memory/file over a valid/ready interface.
- Issues the register-file read address, captures the returned matrix and its dimensions into a local buffer, and emits m*n FP words.
- Pulses ack on completion, or error on illegal dimensions.
- Sits between mpu_register_file (reg_store_addr/matrix_out) and the MPU's memory-side writer.

Parameters:
- FP, 32, element width in bits (IEEE-754 single).
- M, 4, maximum matrix rows.
- N, 4, maximum matrix columns.
- MBITS, $clog2(M), row index width; size ports are MBITS+1 bits.
- NBITS, $clog2(N), column index width; size ports are NBITS+1 bits.
- MATRIX_REG_SIZE, 2, width of the register-file address.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start request; sampled only in IDLE.
- store_addr  in  MATRIX_REG_SIZE  register-file entry to store.
- reg_store_addr  out  MATRIX_REG_SIZE  read address to mpu_register_file.
- matrix_in  in  M*N*FP  register-file matrix_out, flattened, element [i][j] at bits (i*N+j)*FP +: FP.
- reg_m_size  in  MBITS+1  stored row count of the addressed entry.
- reg_n_size  in  NBITS+1  stored column count of the addressed entry.
- element_out  out  FP  current element.
- element_valid  out  1  element_out is valid.
- element_ready  in  1  consumer accepts the element this cycle.
- m_out  out  MBITS+1  row count of the matrix being streamed.
- n_out  out  NBITS+1  column count of the matrix being streamed.
- busy  out  1  high in every non-IDLE state.
- ack  out  1  one-cycle pulse on completion.
- error  out  1  one-cycle pulse on dimension error.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0; local buffer and counters 0.
- IDLE: when en=1, latch store_addr into reg_store_addr and go to FETCH. Otherwise reg_store_addr holds its last value.
- FETCH (1 cycle): wait for the register file's registered read.
- CAPTURE (1 cycle): latch matrix_in, reg_m_size and reg_n_size into the local buffer and m_out/n_out.
  - If m==0, n==0, m>M or n>N: go to ERR.
  - Otherwise clear i,j and go to STREAM.
- STREAM:
  - element_valid=1 and element_out=buf[i][j], both driven from registers.
  - A transfer happens on element_valid && element_ready.
  - On transfer: if j==n-1 then j=0, i=i+1; else j=j+1.
  - On the transfer of (m-1,n-1): drop valid next cycle and go to DONE.
  - With element_ready=0, element_out and valid hold stable indefinitely.
- DONE: ack=1 for exactly one cycle, then IDLE.
- ERR: error=1 for exactly one cycle, ack=0, no elements emitted, then IDLE.
- Latency: en at edge t gives first element_valid at t+3 (IDLE→FETCH→CAPTURE→STREAM). With ready held high, the last element is accepted at t+3+m*n-1 and ack is high in the following cycle.
- en while busy is ignored and not queued. The earliest new start is the cycle after ack/error.
- The buffer is a snapshot: register-file writes after CAPTURE do not affect the streamed data.
- Counter arithmetic is unsigned. Compare against m-1 and n-1 using MBITS+1 and NBITS+1 bit widths, with no wrap past M/N.
- rst mid-operation (any state) forces IDLE next edge. valid, ack and error are 0; no partial ack.

Decomposition:
- global_defs already holds FP, M, N, MBITS, NBITS and MATRIX_REG_SIZE.
- Add a store_state_t enum (IDLE, FETCH, CAPTURE, STREAM, DONE, ERR) to mpu_pkg alongside mpu_operation_t.
- The STREAM row/column index logic is a natural sub-module: mpu_index_counter. It has m/n bounds, an advance input and a last output, and is reusable by mpu_load.
- The buffer and FSM stay in mpu_store.

Test Plan:
- Load 2x2 {1.0, 50.33, -2.5, 0.125} into reg 0 via mpu_load, then en with store_addr=0 and ready=1. Required: element_out sequence 3f800000, 424951ec, c0200000, 3e000000 on 4 consecutive cycles starting at t+3; m_out=n_out=2; ack at t+7 only.
- Same 2x2 matrix with element_ready toggling 1,0,0,1,0,1,1. Required: no element dropped or duplicated; element_out stable while ready=0; ack one cycle after the 4th transfer.
- Full 4x4 in reg 1 with values 1.0..16.0. Required: 16 row-major transfers, then ack; then 3x1 in reg 0 streams exactly 3 words with n_out=1.
- Register entry with dims m=0 or m=5 (>M). Required: error pulse at t+3, element_valid never asserted, ack=0, busy low at t+4.
- en re-asserted during STREAM with store_addr=1. Required: ignored, stream of reg 0 completes unchanged; rst asserted mid-stream: valid/ack 0 next cycle, IDLE, next en restarts cleanly from element [0][0].
